// File: rtl/dsp_bridge_pkg.sv
// Shared types, constants and helpers for the ADC/DAC sample bridge.
// Counters saturate at CNT_MAX instead of wrapping.
package dsp_bridge_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int CNT_W          = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

    // Clear wins over increment; increment sticks at CNT_MAX.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             clr,
        input logic             inc
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (clr) begin
            res = '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/dsp_sample_bridge_sync_fifo.sv
// Synchronous FIFO with a registered head output and RAM-inferable storage.
// A sample written into an empty FIFO is visible on dout the following cycle.
module sync_fifo
    import dsp_bridge_pkg::*;
#(
    parameter int WIDTH      = DATA_W_DEFAULT,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q;
    logic [DEPTH_LOG2:0]   wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]   rd_ptr_d;
    logic                  wr_en;
    logic                  rd_en;
    logic [WIDTH-1:0]      ram_q;
    logic [WIDTH-1:0]      byp_q;
    logic                  byp_sel_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop frees the slot the same cycle, so a push at full is accepted alongside it.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, rd_en};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        ram_q <= mem[rd_ptr_d[DEPTH_LOG2-1:0]];
    end

    // When the next head is the word being written now, the RAM read returns
    // stale data; take the incoming word from the bypass register instead.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            byp_sel_q <= 1'b1;
            byp_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            byp_sel_q <= wr_en && (wr_ptr_q == rd_ptr_d);
            byp_q     <= din;
        end
    end

    assign dout = byp_sel_q ? byp_q : ram_q;

endmodule

// File: rtl/dsp_sample_bridge.sv
// Bridge between the decimating/interpolating DSP datapath and the SoC bus side:
// a capture FIFO fed by the downsampler strobe and a playback FIFO drained by the upsampler strobe.
module dsp_sample_bridge
    import dsp_bridge_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int DEPTH_LOG2     = 9,
    parameter int UNDERFLOW_HOLD = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     down_data,
    input  logic                  down_ce,
    output logic [DATA_W-1:0]     cap_data,
    output logic                  cap_valid,
    input  logic                  cap_ready,
    output logic [DEPTH_LOG2:0]   cap_level,
    output logic [CNT_W-1:0]      cap_overflow_cnt,
    input  logic [DATA_W-1:0]     pb_data,
    input  logic                  pb_valid,
    output logic                  pb_ready,
    output logic [DEPTH_LOG2:0]   pb_level,
    input  logic                  up_ce,
    output logic [DATA_W-1:0]     up_data,
    output logic [CNT_W-1:0]      pb_underflow_cnt,
    input  logic                  cnt_clear
);

    logic                  cap_push;
    logic                  cap_empty;
    logic                  cap_full;
    logic                  cap_drop;
    logic                  pb_push;
    logic                  pb_pop;
    logic                  pb_empty;
    logic                  pb_full;
    logic                  pb_under;
    logic [DATA_W-1:0]     pb_head;

    logic [DATA_W-1:0]     up_data_q;
    logic [DATA_W-1:0]     up_data_d;
    logic [DATA_W-1:0]     last_q;
    logic [DATA_W-1:0]     last_d;
    logic [CNT_W-1:0]      cap_ovf_q;
    logic [CNT_W-1:0]      cap_ovf_d;
    logic [CNT_W-1:0]      pb_unf_q;
    logic [CNT_W-1:0]      pb_unf_d;

    assign cap_push  = down_ce & enable;
    assign cap_valid = ~cap_empty;
    // A strobe at full is only lost if the consumer is not popping this cycle.
    assign cap_drop  = cap_push & cap_full & ~(cap_ready & cap_valid);

    assign pb_ready  = ~pb_full;
    assign pb_push   = pb_valid & pb_ready;
    assign pb_pop    = up_ce & enable;
    assign pb_under  = up_ce & enable & pb_empty;

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_cap_fifo (
        .clk   (sys_clk),
        .srst  (sys_rst),
        .push  (cap_push),
        .pop   (cap_ready),
        .din   (down_data),
        .dout  (cap_data),
        .empty (cap_empty),
        .full  (cap_full),
        .level (cap_level)
    );

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_pb_fifo (
        .clk   (sys_clk),
        .srst  (sys_rst),
        .push  (pb_push),
        .pop   (pb_pop),
        .din   (pb_data),
        .dout  (pb_head),
        .empty (pb_empty),
        .full  (pb_full),
        .level (pb_level)
    );

    always_comb begin
        up_data_d = up_data_q;
        last_d    = last_q;
        if (!enable) begin
            up_data_d = '0;
        end else if (up_ce) begin
            if (!pb_empty) begin
                up_data_d = pb_head;
                last_d    = pb_head;
            end else begin
                // last_q survives an enable-forced zero on up_data, so hold replays the real sample.
                up_data_d = (UNDERFLOW_HOLD != 0) ? last_q : '0;
            end
        end
        cap_ovf_d = cnt_next(cap_ovf_q, cnt_clear, cap_drop);
        pb_unf_d  = cnt_next(pb_unf_q, cnt_clear, pb_under);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            up_data_q <= '0;
            last_q    <= '0;
            cap_ovf_q <= '0;
            pb_unf_q  <= '0;
        end else begin
            up_data_q <= up_data_d;
            last_q    <= last_d;
            cap_ovf_q <= cap_ovf_d;
            pb_unf_q  <= pb_unf_d;
        end
    end

    assign up_data          = up_data_q;
    assign cap_overflow_cnt = cap_ovf_q;
    assign pb_underflow_cnt = pb_unf_q;

endmodule

// File: tb/tb_dsp_sample_bridge.sv
// Scoreboard bench for dsp_sample_bridge: a queue-based reference model predicts FIFO
// contents, levels, counters and up_data; a negedge monitor compares against the DUT.
module tb_dsp_sample_bridge;
    import dsp_bridge_pkg::*;

    localparam int DW             = 16;
    localparam int DL2            = 9;
    localparam int DEPTH          = 1 << DL2;
    localparam int HOLD           = 1;
    localparam int MAX_FAIL_PRINT = 40;

    logic           sys_clk   = 1'b0;
    logic           sys_rst   = 1'b1;
    logic           enable    = 1'b0;
    logic [DW-1:0]  down_data = '0;
    logic           down_ce   = 1'b0;
    logic           cap_ready = 1'b0;
    logic [DW-1:0]  pb_data   = '0;
    logic           pb_valid  = 1'b0;
    logic           up_ce     = 1'b0;
    logic           cnt_clear = 1'b0;

    logic [DW-1:0]  cap_data;
    logic           cap_valid;
    logic [DL2:0]   cap_level;
    logic [15:0]    cap_overflow_cnt;
    logic           pb_ready;
    logic [DL2:0]   pb_level;
    logic [DW-1:0]  up_data;
    logic [15:0]    pb_underflow_cnt;

    dsp_sample_bridge #(
        .DATA_W         (DW),
        .DEPTH_LOG2     (DL2),
        .UNDERFLOW_HOLD (HOLD)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .enable           (enable),
        .down_data        (down_data),
        .down_ce          (down_ce),
        .cap_data         (cap_data),
        .cap_valid        (cap_valid),
        .cap_ready        (cap_ready),
        .cap_level        (cap_level),
        .cap_overflow_cnt (cap_overflow_cnt),
        .pb_data          (pb_data),
        .pb_valid         (pb_valid),
        .pb_ready         (pb_ready),
        .pb_level         (pb_level),
        .up_ce            (up_ce),
        .up_data          (up_data),
        .pb_underflow_cnt (pb_underflow_cnt),
        .cnt_clear        (cnt_clear)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int            cap_level;
        int            pb_level;
        bit            cap_valid;
        bit            pb_ready;
        int            ovf;
        int            unf;
        logic [DW-1:0] up;
        bit            strobe;
    } st_t;

    logic [DW-1:0] m_cap[$];
    logic [DW-1:0] m_pb[$];
    logic [DW-1:0] exp_cap[$];
    st_t           exp_st[$];
    int            m_ovf  = 0;
    int            m_unf  = 0;
    logic [DW-1:0] m_last = '0;
    logic [DW-1:0] m_up   = '0;

    int vectors     = 0;
    int miscompares = 0;
    bit quiet       = 1'b0;
    bit done        = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= MAX_FAIL_PRINT)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < int'(CNT_MAX)) ? v + 1 : v;
    endfunction

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic step();
        st_t s;
        int  pre_cap;
        int  pre_pb;
        bit  cpop;
        bit  drop;
        bit  under;
        drop  = 1'b0;
        under = 1'b0;
        if (sys_rst) begin
            m_cap.delete();
            m_pb.delete();
            m_ovf  = 0;
            m_unf  = 0;
            m_last = '0;
            m_up   = '0;
        end else begin
            pre_cap = m_cap.size();
            cpop    = cap_ready && (pre_cap > 0);
            if (cpop) exp_cap.push_back(m_cap.pop_front());
            if (down_ce && enable) begin
                if (pre_cap < DEPTH || cpop) m_cap.push_back(down_data);
                else drop = 1'b1;
            end
            pre_pb = m_pb.size();
            if (!enable) begin
                m_up = '0;
            end else if (up_ce) begin
                if (pre_pb > 0) begin
                    m_up   = m_pb.pop_front();
                    m_last = m_up;
                end else begin
                    under = 1'b1;
                    m_up  = (HOLD != 0) ? m_last : '0;
                end
            end
            if (pb_valid && pre_pb < DEPTH) m_pb.push_back(pb_data);
            m_ovf = cnt_clear ? 0 : (drop  ? sat_inc(m_ovf) : m_ovf);
            m_unf = cnt_clear ? 0 : (under ? sat_inc(m_unf) : m_unf);
        end
        s.strobe = up_ce && enable && !sys_rst;
        @(posedge sys_clk);
        #1;
        s.cap_level = m_cap.size();
        s.pb_level  = m_pb.size();
        s.cap_valid = (m_cap.size() > 0);
        s.pb_ready  = (m_pb.size() < DEPTH);
        s.ovf       = m_ovf;
        s.unf       = m_unf;
        s.up        = m_up;
        exp_st.push_back(s);
    endtask

    always @(negedge sys_clk) begin : monitor
        st_t           s;
        logic [DW-1:0] e;
        if (cap_valid && cap_ready && !sys_rst) begin
            if (exp_cap.size() == 0) begin
                check("cap_sb_depth", exp_cap.size(), 1);
            end else begin
                e = exp_cap.pop_front();
                check("cap_data", cap_data, e);
                if (!quiet) $display("cap pop: data=0x%04h expected=0x%04h level=%0d", cap_data, e, cap_level);
            end
        end
        while (exp_st.size() > 0) begin
            s = exp_st.pop_front();
            check("cap_level", cap_level, s.cap_level);
            check("pb_level", pb_level, s.pb_level);
            check("cap_valid", cap_valid, s.cap_valid);
            check("pb_ready", pb_ready, s.pb_ready);
            check("cap_overflow_cnt", cap_overflow_cnt, s.ovf);
            check("pb_underflow_cnt", pb_underflow_cnt, s.unf);
            check("up_data", up_data, s.up);
            if (s.strobe && !quiet)
                $display("up strobe: up_data=0x%04h expected=0x%04h underflows=%0d", up_data, s.up, pb_underflow_cnt);
        end
        if (done) begin
            check("cap_sb_leftover", exp_cap.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        // Reset state
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        enable = 1'b1;
        cap_ready = 1'b1;
        step();

        // Capture: sparse strobes, immediate drain
        for (int i = 1; i <= 3; i++) begin
            down_ce = 1'b1;
            down_data = DW'(i);
            step();
            down_ce = 1'b0;
            repeat (3) step();
        end

        // Capture overflow: 514 strobes into 512 entries, then drain
        cap_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            down_ce = 1'b1;
            down_data = DW'(i);
            step();
        end
        down_ce = 1'b0;
        step();
        cap_ready = 1'b1;
        repeat (DEPTH + 3) step();

        // Full FIFO with simultaneous push and pop
        cap_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            down_ce = 1'b1;
            down_data = DW'($urandom);
            step();
        end
        down_ce = 1'b1;
        down_data = 16'hA5C3;
        cap_ready = 1'b1;
        step();
        down_ce = 1'b0;
        cap_ready = 1'b0;
        step();
        repeat (1500) begin
            cap_ready = 1'($urandom_range(0, 1));
            step();
        end
        cap_ready = 1'b1;
        repeat (8) step();

        // Playback extremes and underflow hold
        pb_valid = 1'b1;
        pb_data = 16'h7FFF;
        step();
        pb_data = 16'h8000;
        step();
        pb_valid = 1'b0;
        step();
        repeat (3) begin
            up_ce = 1'b1;
            step();
            up_ce = 1'b0;
            repeat (2) step();
        end

        // Randomized mixed traffic
        for (int i = 0; i < 2000; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            down_ce   = ($urandom_range(0, 2) == 0);
            down_data = DW'($urandom);
            cap_ready = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            pb_valid  = ($urandom_range(0, 1) == 1);
            pb_data   = DW'($urandom);
            up_ce     = ($urandom_range(0, 3) == 0);
            cnt_clear = ($urandom_range(0, 63) == 0);
            step();
        end
        enable = 1'b1;
        cnt_clear = 1'b0;
        down_ce = 1'b0;
        pb_valid = 1'b0;
        cap_ready = 1'b1;
        up_ce = 1'b1;
        repeat (DEPTH + 4) step();

        // Counter saturation on both paths, then clear against increment
        quiet = 1'b1;
        cap_ready = 1'b0;
        down_ce = 1'b1;
        down_data = 16'h1234;
        up_ce = 1'b1;
        repeat (70000) step();
        quiet = 1'b0;
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        down_ce = 1'b0;
        up_ce = 1'b0;
        step();
        cap_ready = 1'b1;
        repeat (DEPTH + 2) step();

        // Reset with buffered data in both FIFOs
        cap_ready = 1'b0;
        down_ce = 1'b1;
        repeat (5) begin
            down_data = DW'($urandom);
            step();
        end
        down_ce = 1'b0;
        pb_valid = 1'b1;
        for (int i = 0; i < 301; i++) begin
            pb_data = DW'($urandom_range(1, 65535));
            up_ce = (i == 150);
            step();
        end
        pb_valid = 1'b0;
        up_ce = 1'b0;
        step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        step();
        up_ce = 1'b1;
        step();
        up_ce = 1'b0;
        repeat (3) step();

        done = 1'b1;
        #200;
        $display("FAIL watchdog: monitor did not reach summary");
        $fatal(1);
    end

endmodule

// File: doc/dsp_sample_bridge.md
Name: dsp_sample_bridge

Overview:
Sits between the ADC→downsampler→DAC datapath and the LiteX SoC side.
- Capture path: buffers decimated samples, strobed by the downsampler clock-enable, in a FIFO that the CPU/DMA drains.
- Playback path: buffers CPU-written samples and presents one to the upsampler input on each upsampler sample strobe.
- Provides handshaked stream ports, fill levels and saturating overflow/underflow counters.

Parameters:
DATA_W, 16, sample width (two's complement)
DEPTH_LOG2, 9, log2 of each FIFO depth (512 entries)
UNDERFLOW_HOLD, 1, 1 = repeat last playback sample on underflow; 0 = output zero

Ports:
sys_clk  in  1  single system clock; all logic on its rising edge
sys_rst  in  1  synchronous reset, active-high
enable  in  1  0 = capture pushes suppressed, playback pops suppressed, up_data forced to 0
down_data  in  DATA_W  decimated sample from downsampler
down_ce  in  1  downsampler ce_out; down_data valid this cycle
cap_data  out  DATA_W  capture FIFO head
cap_valid  out  1  capture FIFO non-empty
cap_ready  in  1  consumer pops head when cap_valid & cap_ready
cap_level  out  DEPTH_LOG2+1  capture FIFO occupancy
cap_overflow_cnt  out  16  dropped capture samples, saturating
pb_data  in  DATA_W  playback sample from CPU/DMA
pb_valid  in  1  producer offers pb_data
pb_ready  out  1  playback FIFO not full; push when pb_valid & pb_ready
pb_level  out  DEPTH_LOG2+1  playback FIFO occupancy
up_ce  in  1  upsampler input strobe; consume one sample
up_data  out  DATA_W  registered sample to upsampler filter_in
pb_underflow_cnt  out  16  up_ce events with empty playback FIFO, saturating
cnt_clear  in  1  synchronous clear of both counters

Behaviour:
Reset (sys_rst = 1 at a clock edge):
- Both FIFOs emptied.
- cap_valid = 0, cap_level = 0, pb_level = 0, pb_ready = 1.
- up_data = 0, both counters = 0.
- Internal "last sample" register = 0.
- Reset mid-transfer discards all buffered data; no partial state survives.

Capture path:
- Push occurs when down_ce & enable & (not full, or pop in the same cycle).
- Push and pop in the same cycle at full: both occur, level unchanged, no overflow.
- down_ce & enable while full with no pop: sample dropped, FIFO contents unchanged, cap_overflow_cnt += 1, saturating at 0xFFFF.
- Write-to-read latency: sample pushed in cycle N into an empty FIFO gives cap_valid = 1 and cap_data = sample in cycle N+1.
- No combinational fall-through.
- cap_data is stable while cap_valid & !cap_ready.

Playback path:
- pb_ready = !full, registered from the current level; it does not depend combinationally on up_ce.
- Push and pop in the same cycle while full: pb_ready is 0, so no push.
- up_ce & enable & non-empty: pop, and up_data <= head at the next edge (1-cycle latency).
- up_data holds its value between strobes.
- up_ce & enable & empty: pb_underflow_cnt += 1, saturating; up_data <= last (UNDERFLOW_HOLD = 1) or 0 (UNDERFLOW_HOLD = 0).
- A push and up_ce in the same cycle on an empty FIFO counts as an underflow. The pushed sample is stored and used at the next strobe.
- enable = 0: up_data <= 0 at the next edge; no pops; pushes are still accepted.

Counters:
- cnt_clear has priority over increment in the same cycle; the result is 0.
- Counters are not cleared by enable.

Widths and levels:
- Levels range 0..2^DEPTH_LOG2.
- Pointers are DEPTH_LOG2+1 bits with wrap bit.
- full = MSBs differ and LSBs are equal; empty = pointers equal.
- Pointer wrap-around is seamless.

Arithmetic:
- Samples pass bit-exact; no scaling or sign manipulation.

Decomposition:
- Shared package dsp_bridge_pkg holds: DATA_W default, CNT_W = 16, CNT_MAX = 16'hFFFF, and the sample type (signed [DATA_W-1:0]).
- One sub-module, sync_fifo, instantiated twice:
  - Parameterised width/depth.
  - Inputs: push, pop, din. Outputs: dout (registered head), empty, full, level.
  - Block-RAM inferable.
- Counter saturation and underflow/hold logic live in the top module.

Test Plan:
- Reset, then enable = 1, down_ce pulsed every 4 cycles with down_data = 0x0001, 0x0002, 0x0003, cap_ready = 1 → cap_data shows 0x0001, 0x0002, 0x0003 each one cycle after the strobe; cap_overflow_cnt = 0.
- cap_ready = 0, 514 down_ce strobes with an incrementing value from 0 → cap_level = 512, cap_overflow_cnt = 2. Then drain: values 0..511 in order, then cap_valid = 0.
- At full, down_ce together with cap_ready in the same cycle → level stays 512, overflow count unchanged; the popped value is the old head.
- Push 0x7FFF, 0x8000 into playback, then two up_ce strobes → up_data = 0x7FFF, then 0x8000, each one cycle after its strobe. A third strobe gives pb_underflow_cnt = 1 and up_data = 0x8000 (HOLD = 1; 0x0000 for HOLD = 0).
- 70000 up_ce strobes on an empty FIFO → pb_underflow_cnt = 0xFFFF. cnt_clear asserted together with up_ce → counter = 0.
- Fill the playback FIFO to 300 entries, assert sys_rst for 1 cycle → pb_level = 0, up_data = 0, pb_ready = 1 on the next cycle; a subsequent up_ce counts as an underflow.
